// File: rtl/nn_pkg.sv
// Shared definitions for the output-layer / training datapath.
// Provides the class count, the signed Q4.12 word type, the common Q4.12
// constants and the streaming-FSM state encoding.
package nn_pkg;

    localparam int unsigned NUM_CLASSES = 10;

    typedef logic signed [15:0] q412_t;

    localparam q412_t Q412_ONE    = 16'h1000;   // 1.0
    localparam q412_t Q412_ZERO   = 16'h0000;   // 0.0
    localparam q412_t Q412_THRESH = 16'h0400;   // 0.25

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

endpackage

// File: rtl/sat_sub16.sv
// Combinational 16-bit signed saturating subtract: y = sat16(a - b).
// Ports:
//   a  in  16  minuend, signed
//   b  in  16  subtrahend, signed
//   y  out 16  difference clamped to [-32768, 32767]
module sat_sub16
    import nn_pkg::*;
(
    input  q412_t a,
    input  q412_t b,
    output q412_t y
);

    logic signed [16:0] diff;

    always_comb begin
        diff = {a[15], a} - {b[15], b};
        // Overflow exactly when the two top bits of the 17-bit result differ;
        // bit 16 then carries the true sign.
        if (diff[16] != diff[15]) begin
            y = diff[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            y = diff[15:0];
        end
    end

endmodule

// File: rtl/label_to_target.sv
// Converts a digit label into the one-hot Q4.12 target vector and streams it
// one class per handshake, together with the saturated error
// (target - output-layer value) for that class. The output-layer vector is
// snapshotted when the label is accepted.
// Ports:
//   clk          in   1        system clock
//   n_rst        in   1        asynchronous active-low reset
//   label_valid  in   1        label offered
//   label        in   4        digit label (legal 0..NUM_CLASSES-1)
//   neural_out   in   N x 16   output-layer values, sampled at accept
//   clear        in   1        synchronous abort, highest priority
//   label_ready  out  1        block idle and able to accept a label
//   tgt_valid    out  1        tgt_* and err_value valid
//   tgt_ready    in   1        downstream accepts current word
//   tgt_index    out  4        class index of current word
//   tgt_value    out  16       target word
//   err_value    out  16       sat(tgt_value - snapshot[tgt_index])
//   tgt_last     out  1        current word is the final class
//   bad_label    out  1        pulse for an out-of-range accepted label
module label_to_target
    import nn_pkg::*;
#(
    parameter int unsigned     NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter int unsigned     WIDTH       = 16,
    parameter logic [WIDTH-1:0] ONE_VAL    = Q412_ONE,
    parameter logic [WIDTH-1:0] ZERO_VAL   = Q412_ZERO
)
(
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                label_valid,
    input  logic [3:0]                          label,
    input  logic [NUM_CLASSES-1:0][WIDTH-1:0]   neural_out,
    input  logic                                clear,
    output logic                                label_ready,
    output logic                                tgt_valid,
    input  logic                                tgt_ready,
    output logic [3:0]                          tgt_index,
    output logic [WIDTH-1:0]                    tgt_value,
    output logic [WIDTH-1:0]                    err_value,
    output logic                                tgt_last,
    output logic                                bad_label
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       label_q;
    logic [WIDTH-1:0] snap_q [NUM_CLASSES];
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic             last_q, last_d;
    logic             bad_q, bad_d;

    logic             accept;
    logic [3:0]       nxt_idx;
    logic [3:0]       nxt_label;
    logic [WIDTH-1:0] nxt_value;
    logic [WIDTH-1:0] nxt_snap;
    q412_t            sub_y;

    assign accept = (state_q == IDLE) && label_valid && !clear;

    // The word presented next is computed one cycle ahead so every output is
    // a plain register. On accept the snapshot is still being loaded, so
    // class 0 takes its operand straight from the input bus.
    always_comb begin
        nxt_idx   = '0;
        nxt_label = label_q;
        nxt_snap  = '0;
        if (state_q == IDLE) begin
            nxt_label = label;
            nxt_snap  = neural_out[0];
        end else if (idx_q < LAST_IDX) begin
            nxt_idx  = idx_q + 4'd1;
            nxt_snap = snap_q[idx_q + 4'd1];
        end
        // Labels beyond the last class never match an index: all ZERO_VAL.
        nxt_value = (nxt_idx == nxt_label) ? ONE_VAL : ZERO_VAL;
    end

    sat_sub16 u_sat (
        .a (nxt_value),
        .b (nxt_snap),
        .y (sub_y)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        value_d = value_q;
        err_d   = err_q;
        last_d  = last_q;
        bad_d   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            value_d = '0;
            err_d   = '0;
            last_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (label_valid) begin
                        state_d = STREAM;
                        idx_d   = nxt_idx;
                        value_d = nxt_value;
                        err_d   = sub_y;
                        last_d  = (nxt_idx == LAST_IDX);
                        bad_d   = (label > LAST_IDX);
                    end
                end
                STREAM: begin
                    if (tgt_ready) begin
                        if (last_q) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            value_d = '0;
                            err_d   = '0;
                            last_d  = 1'b0;
                        end else begin
                            idx_d   = nxt_idx;
                            value_d = nxt_value;
                            err_d   = sub_y;
                            last_d  = (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            label_q <= '0;
            value_q <= '0;
            err_q   <= '0;
            last_q  <= 1'b0;
            bad_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            value_q <= value_d;
            err_q   <= err_d;
            last_q  <= last_d;
            bad_q   <= bad_d;
            if (accept) begin
                label_q <= label;
                for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                    snap_q[i] <= neural_out[i];
                end
            end
        end
    end

    assign label_ready = (state_q == IDLE);
    assign tgt_valid   = (state_q == STREAM);
    assign tgt_index   = idx_q;
    assign tgt_value   = value_q;
    assign err_value   = err_q;
    assign tgt_last    = last_q;
    assign bad_label   = bad_q;

endmodule

// File: doc/label_to_target.md
Name: label_to_target

Overview:
- Inverse of the output-layer digit decode: converts a digit label (0-9) into the 10-entry Q4.12 target vector for training.
- Streams target words one class per handshake to the backprop error unit.
- For each class, also emits the saturated error target minus the output-layer value.
- Output-layer values are snapshotted on label accept, so the network may move on while the stream is in flight.

Parameters:
- NUM_CLASSES, 10, number of output neurons and length of each stream.
- WIDTH, 16, data word width in signed Q4.12.
- ONE_VAL, 16'h1000, target value for the labelled class (1.0 in Q4.12).
- ZERO_VAL, 16'h0000, target value for all other classes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  reset; asynchronous and active-low.
- label_valid  in  1  a label is offered.
- label  in  4  digit label; legal range 0-9.
- neural_out  in  16 x [9:0]  output-layer values, signed Q4.12, sampled at label accept.
- clear  in  1  synchronous abort.
- label_ready  out  1  block can accept a label.
- tgt_valid  out  1  tgt_* and err_value are valid.
- tgt_ready  in  1  downstream accepts the current word.
- tgt_index  out  4  class index of the current word.
- tgt_value  out  16  target word.
- err_value  out  16  signed saturated (tgt_value - snapshot[tgt_index]).
- tgt_last  out  1  current word is class NUM_CLASSES-1.
- bad_label  out  1  one-cycle pulse when an out-of-range label is accepted.

Behaviour:
- Reset (n_rst=0, asynchronous) values:
  - state=IDLE, label_ready=1, tgt_valid=0, tgt_index=0, tgt_value=0, err_value=0, tgt_last=0, bad_label=0.
  - Snapshot registers and stored label are cleared to 0.
- IDLE state:
  - label_ready=1.
  - On label_valid && label_ready, the block captures label and all 10 neural_out words.
  - Same cycle it sets bad_label=1 if label>9, otherwise 0.
  - Next state is STREAM with tgt_index=0.
- STREAM state:
  - label_ready=0 and tgt_valid=1.
  - tgt_value = ONE_VAL when tgt_index == stored label, else ZERO_VAL.
  - For label>9 every word is ZERO_VAL.
  - tgt_last=1 exactly when tgt_index==NUM_CLASSES-1.
  - All tgt_* outputs and err_value are registered and stay stable while tgt_valid && !tgt_ready.
- Handshake:
  - A word transfers on tgt_valid && tgt_ready.
  - On transfer with !tgt_last, tgt_index increments and the new word appears the next cycle, giving a sustained rate of one word per cycle.
  - On transfer with tgt_last, state returns to IDLE, tgt_valid=0 and label_ready=1 the next cycle.
- Latency:
  - Label accept to first word valid is 1 cycle.
  - A full stream takes 10 cycles at tgt_ready=1.
  - Minimum period from one label accept to the next is 11 cycles.
- Error arithmetic:
  - diff = sign-extend-17(tgt_value) - sign-extend-17(snapshot).
  - diff > 32767 saturates to 16'h7FFF; diff < -32768 saturates to 16'h8000; otherwise err_value = diff[15:0].
- clear:
  - Has priority over every handshake in that cycle.
  - Forces IDLE, tgt_valid=0, tgt_index=0 and label_ready=1 on the next cycle.
  - A label offered in the same cycle as clear is not accepted.
  - Snapshot contents are don't-care after clear.
- Other boundaries:
  - label_valid while in STREAM is ignored because label_ready=0.
  - tgt_ready while in IDLE is ignored.
  - n_rst asserted mid-stream returns all outputs to their reset values immediately.
  - bad_label is never asserted outside the accept cycle.

Decomposition:
- Shared package nn_pkg:
  - NUM_CLASSES=10.
  - typedef q412_t (logic signed [15:0]).
  - constants Q412_ONE=16'h1000, Q412_ZERO=16'h0000, Q412_THRESH=16'h0400.
  - state enum {IDLE, STREAM}.
- One sub-module, sat_sub16: a combinational 16-bit signed saturating subtract, reused by the backprop unit.

Test Plan:
- Label 3 with all neural_out=16'h0400 and tgt_ready=1:
  - Words arrive over cycles 1-10 after accept.
  - index 3: tgt_value=16'h1000, err=16'h0C00.
  - all other indices: tgt_value=0, err=16'hFC00.
  - tgt_last only at index 9; label_ready=1 one cycle later.
- Label 0 with tgt_ready toggled 1,0,0,1,...:
  - Outputs hold stable while ready is low.
  - Exactly 10 transfers occur with indices 0..9 in order.
- Label 7 with neural_out[7]=16'h8000 (-8.0) and neural_out[2]=16'h7FFF:
  - index 7: err saturates to 16'h7FFF.
  - index 2: err=16'h8001.
- Label 12: bad_label pulses one cycle, all 10 tgt_value=0, and the stream completes normally.
- Assert clear at index 4 during a label-5 stream:
  - tgt_valid=0 next cycle.
  - A fresh label 9 then streams from index 0 with its own snapshot.
- Pull n_rst low mid-stream at index 6:
  - All outputs take their reset values immediately.
  - After release, label_ready=1 and no stray tgt_valid.
